// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings for MULT/MULTU/DIV/DIVU
//   - controller state enum
//   - HI/LO write-enable encodings
//   - iteration-counter width helper
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_e;

   localparam logic [1:0] HLW_NONE = 2'b00;
   localparam logic [1:0] HLW_BOTH = 2'b11;

   localparam int MDU_WIDTH = 32;

   // Counter holds WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int MDU_CNT_W = cnt_width(MDU_WIDTH);

   function automatic logic is_div_op(input logic [1:0] op);
      return op[1];
   endfunction

   // MULT and DIV are the signed flavours (op[0] = 0).
   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one radix-2 iteration of the multiply/divide datapath.
// Purely combinational; the caller registers hi_o/lo_o back into hi_i/lo_i.
//   isDiv   : 0 = shift-add multiply step, 1 = restoring divide step
//   hi_i    : multiply: upper accumulator half   / divide: partial remainder
//   lo_i    : multiply: lower half + multiplier  / divide: dividend shifting into quotient
//   opnd_i  : multiply: multiplicand magnitude   / divide: divisor magnitude
//   hi_o/lo_o : accumulator after this step
module mdu_iter_core
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             isDiv,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic             fits;
   logic [WIDTH-1:0] diff;

   // Multiply: add into the upper half with carry kept, then shift the whole
   // 2*WIDTH accumulator right one place.
   assign sum = {1'b0, hi_i} + {1'b0, opnd_i};

   // Divide: bring the next dividend bit into the remainder (WIDTH+1 bits).
   // The remainder is always below the divisor, so when the subtraction fits
   // the difference is below the divisor too and WIDTH bits hold it exactly.
   assign shifted = {hi_i, lo_i[WIDTH-1]};
   assign fits    = (shifted >= {1'b0, opnd_i});
   assign diff    = shifted[WIDTH-1:0] - opnd_i;

   always_comb begin
      hi_o = hi_i;
      lo_o = lo_i;
      if (isDiv) begin
         if (fits) begin
            hi_o = diff;
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
         end else begin
            hi_o = shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (lo_i[0]) begin
            {hi_o, lo_o} = {sum, lo_i[WIDTH-1:1]};
         end else begin
            {hi_o, lo_o} = {1'b0, hi_i, lo_i[WIDTH-1:1]};
         end
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU for the EX stage, feeding the
// HI/LO register pair directly.
//   clk, rst (async, active-low)
//   start, op, srcA, srcB : issue request, accepted only in IDLE
//   flush                 : abort in-flight op; also masks the DONE write
//   busy                  : op in flight (CALC or FIX)
//   done, hlWrite         : one-cycle result pulse / HI,LO write enables
//   hiOut, loOut          : result (hi = product high / remainder,
//                                   lo = product low  / quotient)
//
// state | meaning
// IDLE  | waiting for start; latches op, signs and operand magnitudes
// CALC  | WIDTH radix-2 iterations, one per cycle
// FIX   | sign correction, result registered into hiOut/loOut
// DONE  | done=1, hlWrite=11 for one cycle, then back to IDLE
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hiOut,
   output logic [WIDTH-1:0] loOut,
   output logic [1:0]       hlWrite
);

   localparam int             CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mdu_state_e       state_q;
   logic             op_div_q;
   logic             sign_a_q;
   logic             sign_b_q;
   logic             div_zero_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;
   logic [WIDTH-1:0] opnd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [1:0]       hlw_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             issue_div;
   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   logic [WIDTH-1:0] step_hi_d;
   logic [WIDTH-1:0] step_lo_d;

   logic               neg_res;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   hi_fix_d;
   logic [WIDTH-1:0]   lo_fix_d;

   // Operand conditioning at issue: iterations run on magnitudes only.
   assign issue_div = is_div_op(op);
   assign neg_a     = is_signed_op(op) & srcA[WIDTH-1];
   assign neg_b     = is_signed_op(op) & srcB[WIDTH-1];
   assign mag_a     = neg_a ? (-srcA) : srcA;
   assign mag_b     = neg_b ? (-srcB) : srcB;

   mdu_iter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .isDiv  (op_div_q),
      .hi_i   (acc_hi_q),
      .lo_i   (acc_lo_q),
      .opnd_i (opnd_q),
      .hi_o   (step_hi_d),
      .lo_o   (step_lo_d)
   );

   // Sign correction. Quotient sign is the xor of operand signs, remainder
   // follows the dividend (truncation toward zero). A zero divisor leaves the
   // remainder equal to the dividend naturally; only the quotient is forced.
   always_comb begin
      neg_res  = sign_a_q ^ sign_b_q;
      prod     = {acc_hi_q, acc_lo_q};
      prod_fix = neg_res ? (-prod) : prod;
      if (op_div_q) begin
         hi_fix_d = sign_a_q ? (-acc_hi_q) : acc_hi_q;
         lo_fix_d = div_zero_q ? {WIDTH{1'b1}} : (neg_res ? (-acc_lo_q) : acc_lo_q);
      end else begin
         hi_fix_d = prod_fix[2*WIDTH-1:WIDTH];
         lo_fix_d = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         op_div_q   <= 1'b0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         div_zero_q <= 1'b0;
         acc_hi_q   <= '0;
         acc_lo_q   <= '0;
         opnd_q     <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hlw_q      <= HLW_NONE;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start && !flush) begin
                  op_div_q   <= issue_div;
                  sign_a_q   <= neg_a;
                  sign_b_q   <= neg_b;
                  div_zero_q <= issue_div && (srcB == '0);
                  acc_hi_q   <= '0;
                  // Divide shifts the dividend out of lo; multiply shifts
                  // the multiplier out of lo and adds the multiplicand.
                  acc_lo_q   <= issue_div ? mag_a : mag_b;
                  opnd_q     <= issue_div ? mag_b : mag_a;
                  cnt_q      <= CNT_LAST;
                  busy_q     <= 1'b1;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               if (flush) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  acc_hi_q <= step_hi_d;
                  acc_lo_q <= step_lo_d;
                  if (cnt_q == '0) begin
                     state_q <= FIX;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            FIX: begin
               busy_q <= 1'b0;
               if (flush) begin
                  state_q <= IDLE;
               end else begin
                  hi_q    <= hi_fix_d;
                  lo_q    <= lo_fix_d;
                  done_q  <= 1'b1;
                  hlw_q   <= HLW_BOTH;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               hlw_q   <= HLW_NONE;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // A flush arriving in DONE must kill the HI/LO write in that very cycle.
   assign busy    = busy_q;
   assign done    = done_q & ~flush;
   assign hlWrite = flush ? HLW_NONE : hlw_q;
   assign hiOut   = hi_q;
   assign loOut   = lo_q;

endmodule
